// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception sequencer: stalls the pipeline, writes mepc/mstatus/mcause, then redirects.
// Optional build macro CLINT_VECTORED_EN enables vectored-mode redirect for asynchronous traps.
module clint_ctrl #(
  parameter int          INT_W       = 8,
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0007
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_started_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             hold_flag_o,
  output logic             we_o,
  output logic [11:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_W_MRET,
    S_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic        rst_q;
  logic [31:0] epc_q, cause_q;
  logic        async_q, mret_q;

  logic        is_ecall, is_ebreak, is_mret;
  logic        sync_req, mret_req, async_req;
  logic        detect_en, trap_take, mret_take;
  logic [31:0] epc_d, cause_d, base_addr, trap_addr;

  // Detection is blocked while rst is high and in the first cycle after it,
  // so every output stays quiet across that window.
  always_comb begin
    is_ecall  = (inst_i == INST_ECALL);
    is_ebreak = (inst_i == INST_EBREAK);
    is_mret   = (inst_i == INST_MRET);
    sync_req  = is_ecall | is_ebreak;
    mret_req  = is_mret & ~sync_req;
    async_req = ~sync_req & ~is_mret & (int_flag_i != '0) & csr_mstatus_i[3];
    detect_en = (state_q == S_IDLE) & ~rst & ~rst_q;
    trap_take = detect_en & (sync_req | async_req);
    mret_take = detect_en & mret_req;
  end

  always_comb begin
    epc_d   = inst_addr_i;
    cause_d = ASYNC_CAUSE;
    if (is_ecall)         cause_d = 32'd11;
    else if (is_ebreak)   cause_d = 32'd3;
    if (!sync_req) begin
      if (jump_flag_i)        epc_d = jump_addr_i;
      else if (div_started_i) epc_d = inst_addr_i - 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_take)      state_d = S_W_MEPC;
        else if (mret_take) state_d = S_W_MRET;
      end
      S_W_MEPC:    state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_W_MCAUSE;
      S_W_MCAUSE:  state_d = S_REDIRECT;
      S_W_MRET:    state_d = S_REDIRECT;
      S_REDIRECT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rst_q   <= 1'b1;
      epc_q   <= '0;
      cause_q <= '0;
      async_q <= 1'b0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
      if (trap_take) begin
        epc_q   <= epc_d;
        cause_q <= cause_d;
        async_q <= ~sync_req;
        mret_q  <= 1'b0;
      end else if (mret_take) begin
        mret_q  <= 1'b1;
      end
    end
  end

  assign base_addr = {csr_mtvec_i[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  assign trap_addr = (async_q && csr_mtvec_i[1:0] == 2'b01)
                     ? base_addr + {ASYNC_CAUSE[29:0], 2'b00}
                     : base_addr;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = &{1'b0, csr_mtvec_i[1:0], async_q};
  assign trap_addr = base_addr;
`endif

  always_comb begin
    hold_flag_o  = ~rst & ((state_q != S_IDLE) | trap_take | mret_take);
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state_q)
      S_W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = 12'h341;
        data_o  = epc_q;
      end
      S_W_MSTATUS: begin
        we_o      = 1'b1;
        waddr_o   = 12'h300;
        data_o    = csr_mstatus_i;
        data_o[7] = csr_mstatus_i[3];
        data_o[3] = 1'b0;
      end
      S_W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = 12'h342;
        data_o  = cause_q;
      end
      S_W_MRET: begin
        we_o      = 1'b1;
        waddr_o   = 12'h300;
        data_o    = csr_mstatus_i;
        data_o[3] = csr_mstatus_i[7];
        data_o[7] = 1'b1;
      end
      S_REDIRECT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : trap_addr;
      end
      default: ;
    endcase
    if (rst) begin
      we_o         = 1'b0;
      waddr_o      = '0;
      data_o       = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;
    end
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: per-cycle vector table plus hand-written reset-abort and latency sequences.
// Expected vectored-redirect addresses follow CLINT_VECTORED_EN when the bench is built with it.
module tb_clint_ctrl;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ACAUSE = 32'h8000_0007;
`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] VEC_ADDR = 32'h0000_021C;
`else
  localparam logic [31:0] VEC_ADDR = 32'h0000_0200;
`endif
  localparam logic [78:0] Z = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        jump_flag_i, div_started_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [11:0] waddr_o;
  logic [31:0] data_o, int_addr_o;
  logic [78:0] act;

  clint_ctrl #(.INT_W(8), .ASYNC_CAUSE(ACAUSE)) dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .div_started_i(div_started_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i), .hold_flag_o(hold_flag_o), .we_o(we_o),
    .waddr_o(waddr_o), .data_o(data_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  assign act = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};

  typedef struct {
    string       name;
    logic        r;
    logic [7:0]  intf;
    logic [31:0] inst, addr;
    logic        jf;
    logic [31:0] ja;
    logic        dv;
    logic [31:0] mtvec, mepc, mst;
    logic [78:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [78:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [78:0] e(input logic h, input logic w, input logic [11:0] a,
                                    input logic [31:0] d, input logic s, input logic [31:0] t);
    return {h, w, a, d, s, t};
  endfunction

  function automatic vec_t mk(input string name, input logic r, input logic [7:0] intf,
                              input logic [31:0] inst, input logic [31:0] addr, input logic jf,
                              input logic [31:0] ja, input logic dv, input logic [31:0] mtvec,
                              input logic [31:0] mepc, input logic [31:0] mst, input logic [78:0] exp);
    vec_t x;
    x.name = name; x.r = r; x.intf = intf; x.inst = inst; x.addr = addr; x.jf = jf;
    x.ja = ja; x.dv = dv; x.mtvec = mtvec; x.mepc = mepc; x.mst = mst; x.exp = exp;
    return x;
  endfunction

  task automatic add(input string name, input logic r, input logic [7:0] intf,
                     input logic [31:0] inst, input logic [31:0] addr, input logic jf,
                     input logic [31:0] ja, input logic dv, input logic [31:0] mtvec,
                     input logic [31:0] mepc, input logic [31:0] mst, input logic [78:0] exp);
    vecs.push_back(mk(name, r, intf, inst, addr, jf, ja, dv, mtvec, mepc, mst, exp));
  endtask

  task automatic drive(input vec_t x);
    rst = x.r; int_flag_i = x.intf; inst_i = x.inst; inst_addr_i = x.addr;
    jump_flag_i = x.jf; jump_addr_i = x.ja; div_started_i = x.dv;
    csr_mtvec_i = x.mtvec; csr_mepc_i = x.mepc; csr_mstatus_i = x.mst;
  endtask

  task automatic check(input string name, input logic [78:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={hold,we,waddr,data,ia,iaddr}=%h required=%h", name, act, exp);
    end
  endtask

  // Apply inputs just after posedge, compare on the following negedge.
  task automatic step(input vec_t x, input string name, input logic [78:0] exp);
    @(posedge clk); #1;
    drive(x);
    @(negedge clk);
    check(name, exp);
  endtask

  initial begin
    int cyc;
    vec_t x;

    drive(mk("pre", 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0, Z));
    repeat (2) @(posedge clk);

    add("rst_high",    1, 0, ECALL, 32'h100, 0, 0, 0, 32'h200, 0, 32'h8, Z);
    add("rst_after",   0, 0, ECALL, 32'h100, 0, 0, 0, 32'h200, 0, 32'h8, Z);
    add("ecall_T",     0, 0, ECALL, 32'h100, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 0, 0, 0, 0, 0));
    add("ecall_mepc",  0, 0, NOP,   32'h104, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 1, 12'h341, 32'h100, 0, 0));
    add("ecall_mstat", 0, 0, NOP,   32'h104, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 1, 12'h300, 32'h80, 0, 0));
    add("ecall_mcause",0, 0, NOP,   32'h104, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 1, 12'h342, 32'd11, 0, 0));
    add("ecall_redir", 0, 0, NOP,   32'h104, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 0, 0, 0, 1, 32'h200));
    add("ecall_done",  0, 0, NOP,   32'h104, 0, 0, 0, 32'h200, 0, 32'h8, Z);

    add("mret_T",      0, 0, MRET,  32'h200, 0, 0, 0, 32'h200, 32'h104, 32'h80, e(1, 0, 0, 0, 0, 0));
    add("mret_write",  0, 0, NOP,   32'h204, 0, 0, 0, 32'h200, 32'h104, 32'h80, e(1, 1, 12'h300, 32'h88, 0, 0));
    add("mret_redir",  0, 0, NOP,   32'h204, 0, 0, 0, 32'h200, 32'h104, 32'h80, e(1, 0, 0, 0, 1, 32'h104));
    add("mret_done",   0, 0, NOP,   32'h204, 0, 0, 0, 32'h200, 32'h104, 32'h80, Z);

    add("jmp_T",       0, 1, NOP,   32'h200, 1, 32'h340, 1, 32'h200, 0, 32'h8, e(1, 0, 0, 0, 0, 0));
    add("jmp_mepc",    0, 0, NOP,   32'h200, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 1, 12'h341, 32'h340, 0, 0));
    add("jmp_mstat",   0, 0, NOP,   32'h200, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 1, 12'h300, 32'h80, 0, 0));
    add("jmp_mcause",  0, 0, NOP,   32'h200, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 1, 12'h342, ACAUSE, 0, 0));
    add("jmp_redir",   0, 0, NOP,   32'h200, 0, 0, 0, 32'h200, 0, 32'h8, e(1, 0, 0, 0, 1, 32'h200));
    add("jmp_done",    0, 0, NOP,   32'h200, 0, 0, 0, 32'h200, 0, 32'h8, Z);

    add("masked_0",    0, 1, NOP,   32'h200, 1, 32'h340, 0, 32'h200, 0, 32'h0, Z);
    add("masked_1",    0, 1, NOP,   32'h204, 0, 0, 0, 32'h200, 0, 32'h80, Z);

    add("div_T",       0, 1, NOP,   32'h120, 0, 0, 1, 32'h201, 0, 32'h8, e(1, 0, 0, 0, 0, 0));
    add("div_mepc",    0, 0, NOP,   32'h120, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h341, 32'h11C, 0, 0));
    add("div_mstat",   0, 0, NOP,   32'h120, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h300, 32'h80, 0, 0));
    add("div_mcause",  0, 0, NOP,   32'h120, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h342, ACAUSE, 0, 0));
    add("div_redir",   0, 0, NOP,   32'h120, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 0, 0, 0, 1, VEC_ADDR));
    add("div_done",    0, 0, NOP,   32'h120, 0, 0, 0, 32'h201, 0, 32'h8, Z);

    add("ebrk_T",      0, 0, EBREAK,32'h180, 0, 0, 0, 32'h203, 0, 32'h88, e(1, 0, 0, 0, 0, 0));
    add("ebrk_mepc",   0, 0, NOP,   32'h184, 0, 0, 0, 32'h203, 0, 32'h88, e(1, 1, 12'h341, 32'h180, 0, 0));
    add("ebrk_mstat",  0, 0, NOP,   32'h184, 0, 0, 0, 32'h203, 0, 32'h88, e(1, 1, 12'h300, 32'h80, 0, 0));
    add("ebrk_mcause", 0, 0, NOP,   32'h184, 0, 0, 0, 32'h203, 0, 32'h88, e(1, 1, 12'h342, 32'd3, 0, 0));
    add("ebrk_redir",  0, 0, NOP,   32'h184, 0, 0, 0, 32'h203, 0, 32'h88, e(1, 0, 0, 0, 1, 32'h200));
    add("ebrk_done",   0, 0, NOP,   32'h184, 0, 0, 0, 32'h203, 0, 32'h88, Z);

    add("both_T",      0, 1, ECALL, 32'h140, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 0, 0, 0, 0, 0));
    add("both_mepc",   0, 1, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h341, 32'h140, 0, 0));
    add("both_mstat",  0, 1, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h300, 32'h80, 0, 0));
    add("both_mcause", 0, 1, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h342, 32'd11, 0, 0));
    add("both_redir",  0, 1, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 0, 0, 0, 1, 32'h200));
    add("pend_T",      0, 1, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 0, 0, 0, 0, 0));
    add("pend_mepc",   0, 0, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h341, 32'h144, 0, 0));
    add("pend_mstat",  0, 0, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h300, 32'h80, 0, 0));
    add("pend_mcause", 0, 0, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 1, 12'h342, ACAUSE, 0, 0));
    add("pend_redir",  0, 0, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, e(1, 0, 0, 0, 1, VEC_ADDR));
    add("pend_done",   0, 0, NOP,   32'h144, 0, 0, 0, 32'h201, 0, 32'h8, Z);

    foreach (vecs[i]) step(vecs[i], vecs[i].name, vecs[i].exp);

    // Reset pulsed in the W_MSTATUS cycle of a trap: sequence must be abandoned.
    exp_q.push_back(e(1, 0, 0, 0, 0, 0));
    exp_q.push_back(e(1, 1, 12'h341, 32'h300, 0, 0));
    exp_q.push_back(Z);
    for (int k = 0; k < 6; k++) exp_q.push_back(Z);
    step(mk("a", 0, 0, ECALL, 32'h300, 0, 0, 0, 32'h200, 0, 32'h8, Z), "abort_T", exp_q.pop_front());
    step(mk("a", 0, 0, NOP, 32'h304, 0, 0, 0, 32'h200, 0, 32'h8, Z), "abort_mepc", exp_q.pop_front());
    step(mk("a", 1, 0, NOP, 32'h304, 0, 0, 0, 32'h200, 0, 32'h8, Z), "abort_rst", exp_q.pop_front());
    for (int k = 0; k < 6; k++)
      step(mk("a", 0, 0, NOP, 32'h304, 0, 0, 0, 32'h200, 0, 32'h8, Z), "abort_quiet", exp_q.pop_front());

    // Trap latency: redirect 4 cycles after detection, hold released one cycle later.
    step(mk("l", 0, 8'h80, NOP, 32'h400, 0, 0, 0, 32'h200, 0, 32'h8, Z), "lat_T", e(1, 0, 0, 0, 0, 0));
    x = mk("l", 0, 0, NOP, 32'h404, 0, 0, 0, 32'h200, 0, 32'h8, Z);
    cyc = 0;
    do begin
      @(posedge clk); #1; drive(x); @(negedge clk);
      cyc++;
    end while (!int_assert_o && cyc < 10);
    checks++;
    if (!int_assert_o || cyc != 4) begin
      errors++;
      $display("FAIL lat_redirect actual cycles=%0d assert=%b required cycles=4 assert=1", cyc, int_assert_o);
    end
    step(x, "lat_release", Z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
